// File: rtl/load_store_unit.sv
// Load/store unit between the integer datapath and a big-endian word-port data memory.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring low bits.
module load_store_unit #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        dm_cs_q;
    logic        dm_rd_q;
    logic        dm_wr_q;
    logic [31:0] dm_addr_q;
    logic [31:0] dm_din_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_d;
    logic        unused_hi;

    assign addr_d    = {{(32-ADDR_BITS){1'b0}}, req_addr[ADDR_BITS-1:2], 2'b00};
    assign unused_hi = ^req_addr[31:ADDR_BITS];

    function automatic logic [31:0] lane_ext(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00:   lane_ext = {{24{~uns & b[7]}}, b};
            2'b01:   lane_ext = {{16{~uns & h[15]}}, h};
            default: lane_ext = w;
        endcase
    endfunction

    // Replace one byte/half lane of the word just read, keep the rest.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] w,
        input logic [31:0] d,
        input logic [1:0]  sz,
        input logic [1:0]  off
    );
        logic [31:0] m;
        m = w;
        if (sz == 2'b00) begin
            case (off)
                2'd0:    m[31:24] = d[7:0];
                2'd1:    m[23:16] = d[7:0];
                2'd2:    m[15:8]  = d[7:0];
                default: m[7:0]   = d[7:0];
            endcase
        end else if (sz == 2'b01) begin
            if (off[1]) m[15:0]  = d[15:0];
            else        m[31:16] = d[15:0];
        end else begin
            m = d;
        end
        lane_merge = m;
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    logic resp_err_q;
    logic misalign;
    assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size[1] && req_addr[1:0] != 2'b00);
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            dm_cs_q      <= 1'b0;
            dm_rd_q      <= 1'b0;
            dm_wr_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_din_q     <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            wdata_q      <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q        <= 1'b0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        off_q       <= req_addr[1:0];
                        wdata_q     <= req_wdata;
                        dm_addr_q   <= addr_d;
                        req_ready_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                        // Trapped accesses idle one cycle in LOAD with no memory cycle.
                        if (misalign) begin
                            err_q   <= 1'b1;
                            state_q <= LOAD;
                        end else
`endif
                        if (!req_we) begin
                            state_q <= LOAD;
                            dm_cs_q <= 1'b1;
                            dm_rd_q <= 1'b1;
                        end else if (req_size[1]) begin
                            state_q  <= STORE;
                            dm_cs_q  <= 1'b1;
                            dm_wr_q  <= 1'b1;
                            dm_din_q <= req_wdata;
                        end else begin
                            state_q <= RMW_RD;
                            dm_cs_q <= 1'b1;
                            dm_rd_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_q      <= RESP;
                    dm_cs_q      <= 1'b0;
                    dm_rd_q      <= 1'b0;
                    resp_valid_q <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                    resp_err_q   <= err_q;
                    resp_rdata_q <= err_q ? '0 :
                                    lane_ext(dm_dout, size_q, off_q, uns_q);
`else
                    resp_rdata_q <= lane_ext(dm_dout, size_q, off_q, uns_q);
`endif
                end
                RMW_RD: begin
                    state_q  <= RMW_WR;
                    dm_rd_q  <= 1'b0;
                    dm_wr_q  <= 1'b1;
                    dm_din_q <= lane_merge(dm_dout, wdata_q, size_q, off_q);
                end
                STORE, RMW_WR: begin
                    state_q      <= RESP;
                    dm_cs_q      <= 1'b0;
                    dm_wr_q      <= 1'b0;
                    dm_din_q     <= '0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
                    resp_err_q   <= 1'b0;
`endif
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                    err_q       <= 1'b0;
`endif
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    dm_cs_q     <= 1'b0;
                    dm_rd_q     <= 1'b0;
                    dm_wr_q     <= 1'b0;
                    dm_din_q    <= '0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign dm_cs      = dm_cs_q;
    assign dm_rd      = dm_rd_q;
    assign dm_wr      = dm_wr_q;
    assign dm_addr    = dm_addr_q;
    assign dm_din     = dm_din_q;

endmodule
